// File: rtl/hyperram_if.sv
// HyperBus pin bundle between a host (master) and the device-side responder (slave).
// Single-data-rate view: one 16-bit DQ word and one RWDS bit per enabled clk beat.
interface hyperram_if;
  logic        csn;
  logic        ck_en;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        rwds_in;
  logic        rwds_out;
  logic        rwds_oe;

  modport master (
    output csn, ck_en, dq_in, rwds_in,
    input  dq_out, dq_oe, rwds_out, rwds_oe
  );

  modport slave (
    input  csn, ck_en, dq_in, rwds_in,
    output dq_out, dq_oe, rwds_out, rwds_oe
  );
endinterface

// File: rtl/hyperram_responder.sv
// HyperBus device-side responder: decodes the 48-bit CA phase, applies initial latency,
// and serves a 2^ADDR_W x 16 memory plus the ID0/ID1/CR0/CR1 register space.
module hyperram_responder #(
  parameter int          ADDR_W   = 10,
  parameter int          LATENCY  = 6,
  parameter int          FIXED_2X = 1,
  parameter logic [15:0] ID0_VAL  = 16'h0c81,
  parameter logic [15:0] ID1_VAL  = 16'h0001,
  parameter logic [15:0] CR0_RST  = 16'h8f1f,
  parameter logic [15:0] CR1_RST  = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  hyperram_if.slave   bus,
  output logic [15:0] cr0,
  output logic [15:0] cr1
);

  localparam int   LAT_W    = 8;
  localparam int   LAT_LOAD = LATENCY * ((FIXED_2X != 0) ? 2 : 1) - 1;
  localparam logic RWDS_CA  = (FIXED_2X != 0);

  typedef enum logic [2:0] {IDLE, CA, LAT, RDATA, WDATA, REGW} state_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [15:0]       ca_hi_q, ca_hi_d;
  logic [15:0]       ca_mid_q, ca_mid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        sel_q, sel_d;
  logic              is_read_q, is_read_d;
  logic              is_reg_q, is_reg_d;
  logic              linear_q, linear_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              rwds_out_q, rwds_out_d;
  logic              rwds_oe_q, rwds_oe_d;
  logic [15:0]       cr0_q, cr0_d;
  logic [15:0]       cr1_q, cr1_d;

  logic [15:0]       mem [2**ADDR_W];
  logic              mem_we;
  logic [15:0]       mem_rd;
  logic [15:0]       reg_val;
  logic [47:0]       ca_full;
  logic [ADDR_W-1:0] ca_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              unused_ca;

  // The third CA word is decoded straight off the bus on the beat that delivers it.
  assign ca_full   = {ca_hi_q, ca_mid_q, bus.dq_in};
  assign ca_addr   = ADDR_W'({ca_full[44:16], ca_full[2:0]});
  assign unused_ca = ^ca_full;

  assign addr_inc = linear_q ? (addr_q + ADDR_W'(1))
                             : {addr_q[ADDR_W-1:4], addr_q[3:0] + 4'd1};

  assign mem_rd = mem[addr_q];

  always_comb begin
    reg_val = ID0_VAL;
    unique case (sel_q)
      2'b00: reg_val = ID0_VAL;
      2'b01: reg_val = ID1_VAL;
      2'b10: reg_val = cr0_q;
      2'b11: reg_val = cr1_q;
      default: reg_val = ID0_VAL;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    ca_hi_d    = ca_hi_q;
    ca_mid_d   = ca_mid_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    is_read_d  = is_read_q;
    is_reg_d   = is_reg_q;
    linear_d   = linear_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = dq_oe_q;
    rwds_out_d = rwds_out_q;
    rwds_oe_d  = rwds_oe_q;
    cr0_d      = cr0_q;
    cr1_d      = cr1_q;
    mem_we     = 1'b0;

    if (bus.csn) begin
      // Deselect wins over any beat on the same edge, including data beats.
      state_d    = IDLE;
      beat_d     = 2'd0;
      lat_d      = '0;
      dq_out_d   = 16'h0000;
      dq_oe_d    = 1'b0;
      rwds_out_d = 1'b0;
      rwds_oe_d  = 1'b0;
    end else if (bus.ck_en) begin
      unique case (state_q)
        IDLE: begin
          ca_hi_d    = bus.dq_in;
          beat_d     = 2'd1;
          state_d    = CA;
          rwds_oe_d  = 1'b1;
          rwds_out_d = RWDS_CA;
        end
        CA: begin
          if (beat_q == 2'd1) begin
            ca_mid_d = bus.dq_in;
            beat_d   = 2'd2;
          end else begin
            beat_d     = 2'd0;
            rwds_oe_d  = 1'b0;
            rwds_out_d = 1'b0;
            is_read_d  = ca_full[47];
            is_reg_d   = ca_full[46];
            linear_d   = ca_full[45];
            addr_d     = ca_addr;
            sel_d      = {ca_full[24], ca_full[0]};
            if (!ca_full[47] && ca_full[46]) begin
              state_d = REGW;
            end else begin
              state_d = LAT;
              lat_d   = LAT_W'(LAT_LOAD);
            end
          end
        end
        LAT: begin
          if (lat_q == '0) begin
            state_d = is_read_q ? RDATA : WDATA;
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end
        RDATA: begin
          dq_out_d   = is_reg_q ? reg_val : mem_rd;
          dq_oe_d    = 1'b1;
          rwds_out_d = 1'b1;
          rwds_oe_d  = 1'b1;
          if (!is_reg_q) begin
            addr_d = addr_inc;
          end
        end
        WDATA: begin
          mem_we = !bus.rwds_in;
          addr_d = addr_inc;
        end
        REGW: begin
          // Only the first data beat lands; ID registers are read-only.
          if (beat_q == 2'd0) begin
            beat_d = 2'd1;
            if (sel_q == 2'b10) cr0_d = bus.dq_in;
            if (sel_q == 2'b11) cr1_d = bus.dq_in;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == RDATA) begin
      rwds_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= bus.dq_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      lat_q      <= '0;
      ca_hi_q    <= 16'h0000;
      ca_mid_q   <= 16'h0000;
      addr_q     <= '0;
      sel_q      <= 2'b00;
      is_read_q  <= 1'b0;
      is_reg_q   <= 1'b0;
      linear_q   <= 1'b0;
      dq_out_q   <= 16'h0000;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
      cr0_q      <= CR0_RST;
      cr1_q      <= CR1_RST;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      ca_hi_q    <= ca_hi_d;
      ca_mid_q   <= ca_mid_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      is_read_q  <= is_read_d;
      is_reg_q   <= is_reg_d;
      linear_q   <= linear_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rwds_out_q <= rwds_out_d;
      rwds_oe_q  <= rwds_oe_d;
      cr0_q      <= cr0_d;
      cr1_q      <= cr1_d;
    end
  end

  assign bus.dq_out   = dq_out_q;
  assign bus.dq_oe    = dq_oe_q;
  assign bus.rwds_out = rwds_out_q;
  assign bus.rwds_oe  = rwds_oe_q;
  assign cr0          = cr0_q;
  assign cr1          = cr1_q;

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed + randomized bench for hyperram_responder against a word-array model of
// the device memory and register file.
module tb_hyperram_responder;

  localparam int AW        = 10;
  localparam int DEPTH     = 1 << AW;
  localparam int LAT_BEATS = 6 * 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cr0;
  logic [15:0] cr1;

  hyperram_if bus();

  hyperram_responder #(
    .ADDR_W(AW), .LATENCY(6), .FIXED_2X(1),
    .ID0_VAL(16'h0c81), .ID1_VAL(16'h0001),
    .CR0_RST(16'h8f1f), .CR1_RST(16'h0002)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cr0(cr0),
    .cr1(cr1)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] model [DEPTH];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic e, input logic [15:0] d, input logic r);
    bus.csn     = c;
    bus.ck_en   = e;
    bus.dq_in   = d;
    bus.rwds_in = r;
    @(posedge clk);
    #1;
  endtask

  function automatic int nxt(input int a, input bit lin);
    if (lin) return (a + 1) % DEPTH;
    return (a / 16) * 16 + ((a % 16) + 1) % 16;
  endfunction

  task automatic maybe_gap(input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0)
      drive(1'b0, 1'b0, 16'($urandom), 1'($urandom));
  endtask

  task automatic send_ca(input bit rd, input bit rg, input bit lin, input int addr,
                         input logic [1:0] sel, input bit gaps);
    logic [47:0] ca;
    ca     = '0;
    ca[47] = rd;
    ca[46] = rg;
    ca[45] = lin;
    if (rg) begin
      ca[24] = sel[1];
      ca[0]  = sel[0];
    end else begin
      ca[44:16] = 29'(addr / 8);
      ca[2:0]   = 3'(addr % 8);
    end
    for (int i = 0; i < 3; i++) begin
      maybe_gap(gaps);
      drive(1'b0, 1'b1, ca[47-16*i -: 16], 1'b0);
    end
  endtask

  task automatic lat_wait(input bit gaps);
    for (int i = 0; i < LAT_BEATS; i++) begin
      maybe_gap(gaps);
      drive(1'b0, 1'b1, 16'h0000, 1'b0);
    end
    check("lat_dq_oe", {15'b0, bus.dq_oe}, 16'h0000);
  endtask

  task automatic end_xfer();
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    check("deselect_dq_oe", {15'b0, bus.dq_oe}, 16'h0000);
  endtask

  task automatic mem_write(input int addr, input bit lin, input logic [15:0] data[$],
                           input bit mask[$], input bit gaps);
    int a;
    send_ca(1'b0, 1'b0, lin, addr, 2'b00, gaps);
    lat_wait(gaps);
    a = addr;
    for (int i = 0; i < data.size(); i++) begin
      maybe_gap(gaps);
      drive(1'b0, 1'b1, data[i], mask[i]);
      if (!mask[i]) model[a] = data[i];
      a = nxt(a, lin);
    end
    end_xfer();
  endtask

  task automatic mem_read(input int addr, input bit lin, input int n, input bit gaps,
                          input string tag);
    int          a;
    logic [15:0] prev;
    send_ca(1'b1, 1'b0, lin, addr, 2'b00, gaps);
    lat_wait(gaps);
    a    = addr;
    prev = 16'h0000;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        check("gap_rwds_low", {15'b0, bus.rwds_out}, 16'h0000);
        check("gap_dq_hold", bus.dq_out, prev);
      end
      drive(1'b0, 1'b1, 16'h0000, 1'b0);
      check(tag, bus.dq_out, model[a]);
      check("rd_rwds", {15'b0, bus.rwds_out}, 16'h0001);
      prev = model[a];
      a    = nxt(a, lin);
    end
    end_xfer();
  endtask

  task automatic reg_read(input logic [1:0] sel, input logic [15:0] exp, input string tag);
    send_ca(1'b1, 1'b1, 1'b0, 0, sel, 1'b0);
    lat_wait(1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 16'h0000, 1'b0);
      check(tag, bus.dq_out, exp);
      check("reg_rd_dq_oe", {15'b0, bus.dq_oe}, 16'h0001);
    end
    end_xfer();
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [15:0] data);
    send_ca(1'b0, 1'b1, 1'b1, 0, sel, 1'b0);
    drive(1'b0, 1'b1, data, 1'b1);
    drive(1'b0, 1'b1, ~data, 1'b0);
    end_xfer();
  endtask

  logic [15:0] dq[$];
  bit          mq[$];
  logic [15:0] cr1_exp;
  int          ra;
  int          rn;
  bit          rlin;

  initial begin
    rst         = 1'b0;
    bus.csn     = 1'b1;
    bus.ck_en   = 1'b0;
    bus.dq_in   = 16'h0000;
    bus.rwds_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dq_oe", {15'b0, bus.dq_oe}, 16'h0000);
    check("rst_rwds_oe", {15'b0, bus.rwds_oe}, 16'h0000);
    check("rst_dq_out", bus.dq_out, 16'h0000);
    check("rst_cr0", cr0, 16'h8f1f);
    check("rst_cr1", cr1, 16'h0002);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0000, 1'b0);

    // ID0 read with the CA-phase RWDS latency indicator
    drive(1'b0, 1'b1, 16'hc000, 1'b0);
    check("ca1_rwds_oe", {15'b0, bus.rwds_oe}, 16'h0001);
    check("ca1_rwds_out", {15'b0, bus.rwds_out}, 16'h0001);
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    check("ca2_rwds_oe", {15'b0, bus.rwds_oe}, 16'h0001);
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    check("ca3_rwds_oe", {15'b0, bus.rwds_oe}, 16'h0000);
    lat_wait(1'b0);
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    check("id0_dq_out", bus.dq_out, 16'h0c81);
    check("id0_dq_oe", {15'b0, bus.dq_oe}, 16'h0001);
    check("id0_rwds", {15'b0, bus.rwds_out}, 16'h0001);
    end_xfer();
    reg_read(2'b01, 16'h0001, "id1_read");

    // Register writes: CR0, CR1, and an ignored ID0 write
    reg_write(2'b10, 16'h8fe7);
    check("cr0_written", cr0, 16'h8fe7);
    reg_read(2'b10, 16'h8fe7, "cr0_read");
    cr1_exp = 16'($urandom);
    reg_write(2'b11, cr1_exp);
    check("cr1_written", cr1, cr1_exp);
    reg_read(2'b11, cr1_exp, "cr1_read");
    reg_write(2'b00, 16'hffff);
    reg_read(2'b00, 16'h0c81, "id0_ro");
    check("cr0_kept", cr0, 16'h8fe7);

    // Fill the whole array so every later read has a known expectation
    dq.delete(); mq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      dq.push_back(16'($urandom));
      mq.push_back(1'b0);
    end
    mem_write(0, 1'b1, dq, mq, 1'b0);
    mem_read(0, 1'b1, 8, 1'b0, "fill_read");

    // Linear burst across the top of the array
    dq = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    mq = {1'b0, 1'b0, 1'b0, 1'b0};
    mem_write(10'h3fe, 1'b1, dq, mq, 1'b0);
    mem_read(10'h3fe, 1'b1, 5, 1'b0, "lin_wrap_read");

    // Wrapped burst with the second beat masked
    dq = {16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd};
    mq = {1'b0, 1'b1, 1'b0, 1'b0};
    mem_write(10'h00e, 1'b0, dq, mq, 1'b0);
    mem_read(10'h00e, 1'b0, 4, 1'b0, "wrap_mask_read");
    mem_read(10'h010, 1'b1, 1, 1'b0, "wrap_no_spill");

    // Abort mid-latency, then a fresh read decodes normally
    send_ca(1'b0, 1'b0, 1'b1, 10'h120, 2'b00, 1'b0);
    repeat (5) drive(1'b0, 1'b1, 16'h5a5a, 1'b0);
    end_xfer();
    mem_read(10'h120, 1'b1, 3, 1'b0, "abort_lat_read");

    // csn rising on a data beat cancels that beat
    send_ca(1'b0, 1'b0, 1'b1, 10'h200, 2'b00, 1'b0);
    lat_wait(1'b0);
    drive(1'b0, 1'b1, 16'h7777, 1'b0);
    model[10'h200] = 16'h7777;
    drive(1'b1, 1'b1, 16'h8888, 1'b0);
    mem_read(10'h200, 1'b1, 2, 1'b0, "abort_data_read");

    // Abort mid-read: outputs released on the edge after csn rises
    send_ca(1'b1, 1'b0, 1'b1, 10'h300, 2'b00, 1'b0);
    lat_wait(1'b0);
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    check("pre_abort_rd", bus.dq_out, model[10'h300]);
    drive(1'b1, 1'b1, 16'h0000, 1'b0);
    check("abort_rd_dq_oe", {15'b0, bus.dq_oe}, 16'h0000);
    check("abort_rd_dq_out", bus.dq_out, 16'h0000);
    check("abort_rd_rwds_oe", {15'b0, bus.rwds_oe}, 16'h0000);

    // Randomized traffic with ck_en gaps anywhere in the transaction
    for (int t = 0; t < 24; t++) begin
      ra   = $urandom_range(0, DEPTH - 1);
      rlin = 1'($urandom_range(0, 1));
      rn   = $urandom_range(1, 20);
      if ($urandom_range(0, 1) == 1) begin
        dq.delete(); mq.delete();
        for (int i = 0; i < rn; i++) begin
          dq.push_back(16'($urandom));
          mq.push_back($urandom_range(0, 3) == 0);
        end
        mem_write(ra, rlin, dq, mq, 1'b1);
      end else begin
        mem_read(ra, rlin, rn, 1'b1, "rand_read");
      end
    end

    // Asynchronous reset in the middle of a read
    send_ca(1'b1, 1'b0, 1'b1, 10'h050, 2'b00, 1'b0);
    lat_wait(1'b0);
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    check("pre_rst_dq_oe", {15'b0, bus.dq_oe}, 16'h0001);
    #2;
    rst = 1'b0;
    #1;
    check("arst_dq_oe", {15'b0, bus.dq_oe}, 16'h0000);
    check("arst_rwds_oe", {15'b0, bus.rwds_oe}, 16'h0000);
    check("arst_dq_out", bus.dq_out, 16'h0000);
    check("arst_cr0", cr0, 16'h8f1f);
    check("arst_cr1", cr1, 16'h0002);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    mem_read(10'h3fe, 1'b1, 4, 1'b0, "retained_read");
    mem_read(10'h050, 1'b1, 4, 1'b0, "retained_read2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hyperram_responder.md
Name: hyperram_responder

Overview:
- Synthesizable HyperBus device-side responder, the target end of hyperram_controller's bus.
- Decodes the 48-bit command/address (CA) phase, inserts the initial access latency, and returns or accepts 16-bit words from an internal memory array.
- Also serves the ID0/ID1/CR0/CR1 register space.
- Used as the controller's closed-loop bench partner and as an FPGA loopback target; single-data-rate model, one 16-bit beat per enabled clk.

Parameters:
- ADDR_W, 10: word-address width of the backing array (2^ADDR_W x 16-bit words).
- LATENCY, 6: initial latency in enabled clk beats (1x count).
- FIXED_2X, 1: 1 = always double latency (RWDS driven high during CA), 0 = always 1x (RWDS driven low).
- ID0_VAL, 16'h0c81: read-only ID register 0.
- ID1_VAL, 16'h0001: read-only ID register 1.
- CR0_RST, 16'h8f1f: CR0 reset value.
- CR1_RST, 16'h0002: CR1 reset value.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- csn  in  1  chip select from host, active-low
- ck_en  in  1  host bus-clock enable; a beat occurs only on clk edges with ck_en=1
- dq_in  in  16  host-driven data/CA word
- dq_out  out  16  responder-driven read data
- dq_oe  out  1  responder drives DQ
- rwds_in  in  1  host RWDS during writes (1 = word masked)
- rwds_out  out  1  responder RWDS (latency indicator during CA, data strobe during read)
- rwds_oe  out  1  responder drives RWDS
- cr0  out  16  current CR0 value, for visibility
- cr1  out  16  current CR1 value, for visibility

Behaviour:
- Reset (rst=0, async): state=IDLE; dq_out=0, dq_oe=0, rwds_out=0, rwds_oe=0; cr0=CR0_RST, cr1=CR1_RST; beat and latency counters 0. Memory contents are not reset.
- All outputs are registered.
- csn=1 at any clk edge forces IDLE on that edge: dq_oe=0, rwds_oe=0, dq_out=0, counters cleared. This aborts any in-progress burst; writes already committed are kept.
- States: IDLE, CA, LAT, RDATA, WDATA, REGW.
- IDLE: on csn=0 with ck_en=1, capture dq_in as CA[47:32], go to CA (beat count=1). Drive rwds_oe=1, rwds_out=FIXED_2X from this edge until the end of CA.
- CA: beat 2 captures CA[31:16]; beat 3 captures CA[15:0], then rwds_oe=0.
- CA decode: CA[47]=1 read / 0 write; CA[46]=1 register space; CA[45]=1 linear / 0 wrapped burst.
- Word address = {CA[44:16],CA[2:0]} truncated to ADDR_W.
- Register select = {CA[24],CA[0]}: 00 ID0, 01 ID1, 10 CR0, 11 CR1.
- After beat 3:
  - register write (CA[47]=0, CA[46]=1) -> REGW, zero latency;
  - all other transactions -> LAT with load = LATENCY*(FIXED_2X?2:1) - 1.
- LAT: decrement the counter on each ck_en beat; at 0 go to RDATA (read) or WDATA (write). No outputs are driven.
- RDATA, every ck_en beat:
  - dq_out = mem[addr] for memory, or the selected register for register space;
  - dq_oe=1, rwds_out=1, rwds_oe=1.
  - Memory reads advance the address; register reads repeat the same register.
  - Beats with ck_en=0 hold dq_out and set rwds_out=0.
- WDATA, every ck_en beat: if rwds_in=0 then mem[addr]<=dq_in; advance the address whether or not the beat is masked. dq_oe stays 0.
- Memory-space writes only. A register-space write that went through latency does not exist; see REGW.
- REGW: first ck_en beat writes dq_in to CR0 or CR1 per select; ID writes are ignored; rwds_in is ignored. Then hold in REGW, ignoring further beats, until csn=1.
- Address advance:
  - linear: addr+1 modulo 2^ADDR_W;
  - wrapped: addr[3:0]+1 modulo 16 with the upper bits held (16-word wrap).
- csn deasserting during CA or LAT: no access occurs.
- csn deasserting on the same edge as a data beat: that beat is not performed (csn has priority).
- CA beats with ck_en=0 are not counted; partial CA is held.

Test Plan:
- Register read ID0: CA 16'hc000,16'h0000,16'h0000, wait 12 beats -> rwds_oe=1/rwds_out=1 during CA; after latency dq_oe=1, dq_out=16'h0c81, rwds_out=1.
- CR0 write then read: CA 16'h6000,16'h0100,16'h0000 then data 16'h8fe7 with zero latency -> cr0=16'h8fe7; read CA 16'hc000,16'h0100,16'h0000 -> dq_out=16'h8fe7.
- Linear burst: write 16'h1111..16'h4444 to word 0x3fe (CA 16'h2000,16'h01ff,16'h0006), rwds_in=0 -> mem[0x3fe],[0x3ff],[0x000],[0x001] written (address wrap). A linear read of the same 4 words returns 16'h1111,16'h2222,16'h3333,16'h4444.
- Wrapped burst + mask: write 4 words starting at word 0x0e in wrapped mode (CA[45]=0) with rwds_in=1 on the 2nd beat -> words 0x0e, 0x00, 0x01 written; word 0x0f unchanged.
- Abort: csn=1 in the middle of LAT, then a new read -> the new transaction decodes normally; no memory changes; dq_oe=0 on the edge after csn rises.
- Async reset mid-RDATA: rst=0 -> dq_oe, rwds_oe, dq_out go to 0 immediately without a clk edge; cr0=16'h8f1f, cr1=16'h0002; memory content retained.
